// File: rtl/fetcher_if.sv
// fetcher_if: handshake and memory bus bundle for the instruction fetcher.
//   Execute side : JUMP_DEST, EXEC_DONE, HALT_REQ (into fetcher)
//   Decode side  : INSTR, PC, INSTR_VALID (out), INSTR_READY (in)
//   IMEM side    : IMEM_EN, IMEM_ADDR (out), IMEM_DATA (in, 1-cycle latency)
//   Status       : RETIRED, HALTED, FAULT (out)
// Modport master is the fetcher's view; slave is the surrounding system's view.
interface fetcher_if #(
   parameter int unsigned IMEM_ADDR_WIDTH = 10
);
   logic [31:0]                JUMP_DEST;
   logic                       EXEC_DONE;
   logic                       HALT_REQ;
   logic                       INSTR_READY;
   logic [31:0]                IMEM_DATA;
   logic                       IMEM_EN;
   logic [IMEM_ADDR_WIDTH-1:0] IMEM_ADDR;
   logic [31:0]                PC;
   logic [31:0]                INSTR;
   logic                       INSTR_VALID;
   logic [31:0]                RETIRED;
   logic                       HALTED;
   logic                       FAULT;

   modport master (
      input  JUMP_DEST, EXEC_DONE, HALT_REQ, INSTR_READY, IMEM_DATA,
      output IMEM_EN, IMEM_ADDR, PC, INSTR, INSTR_VALID, RETIRED, HALTED, FAULT
   );

   modport slave (
      output JUMP_DEST, EXEC_DONE, HALT_REQ, INSTR_READY, IMEM_DATA,
      input  IMEM_EN, IMEM_ADDR, PC, INSTR, INSTR_VALID, RETIRED, HALTED, FAULT
   );
endinterface

// File: rtl/fetcher.sv
// fetcher: multicycle instruction-fetch sequencer.
//   CLK  : single clock, rising edge
//   RSTN : asynchronous active-low reset
//   bus  : fetcher_if.master (execute handshake, decode handshake, IMEM port,
//          retire counter, halt/fault status)
// Sequence per instruction: REQ (read strobe) -> WAIT (capture data) ->
// ISSUE (valid/ready to decode) -> EXEC (wait for execute, take next PC).
// Out-of-range next PC sets a sticky FAULT and halts with PC unchanged.
module fetcher #(
   parameter logic [31:0] RESET_PC        = '0,
   parameter int unsigned IMEM_ADDR_WIDTH = 10
) (
   input  logic     CLK,
   input  logic     RSTN,
   fetcher_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } state_t;

   // 33-bit limit so a full 32-bit address space never reports out-of-range.
   localparam logic [32:0] PC_LIMIT = 33'd1 << IMEM_ADDR_WIDTH;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] retired_q, retired_d;
   logic        fault_q, fault_d;
   logic        jump_oob;

   assign jump_oob = ({1'b0, bus.JUMP_DEST} >= PC_LIMIT);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      fault_d   = fault_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   state_d = S_WAIT;
         S_WAIT: begin
            instr_d = bus.IMEM_DATA;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (bus.INSTR_READY) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (bus.EXEC_DONE) begin
               retired_d = retired_q + 32'd1;
               if (jump_oob) begin
                  fault_d = 1'b1;
                  state_d = S_HALT;
               end else begin
                  pc_d    = bus.JUMP_DEST;
                  state_d = bus.HALT_REQ ? S_HALT : S_REQ;
               end
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         fault_q   <= fault_d;
      end
   end

   // Strobes decode from the state register only: no input-to-output path.
   assign bus.IMEM_EN     = (state_q == S_REQ);
   assign bus.INSTR_VALID = (state_q == S_ISSUE);
   assign bus.HALTED      = (state_q == S_HALT);
   assign bus.IMEM_ADDR   = pc_q[IMEM_ADDR_WIDTH-1:0];
   assign bus.PC          = pc_q;
   assign bus.INSTR       = instr_q;
   assign bus.RETIRED     = retired_q;
   assign bus.FAULT       = fault_q;

endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: directed/randomized bench for fetcher with a transaction-level
// reference (expected PC, retire count, fault/halt flags, memory image).
module tb_fetcher;
   localparam int unsigned AW = 10;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fetcher_if #(.IMEM_ADDR_WIDTH(AW)) bus ();

   fetcher #(.RESET_PC(32'd0), .IMEM_ADDR_WIDTH(AW)) dut (
      .CLK  (clk),
      .RSTN (rst_n),
      .bus  (bus)
   );

   // Instruction memory: synchronous read, one-cycle latency.
   logic [31:0] mem [1024];
   always @(posedge clk) if (bus.IMEM_EN) bus.IMEM_DATA <= mem[bus.IMEM_ADDR];

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_pc;
   logic [31:0] exp_ret;
   bit          exp_fault;
   bit          exp_halt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Asserts reset (asynchronously), checks outputs with no clock edge,
   // releases on a falling edge and advances into REQ.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_pc",      bus.PC, 32'd0);
      chk("rst_instr",   bus.INSTR, 32'd0);
      chk("rst_valid",   32'(bus.INSTR_VALID), 32'd0);
      chk("rst_en",      32'(bus.IMEM_EN), 32'd0);
      chk("rst_retired", bus.RETIRED, 32'd0);
      chk("rst_halted",  32'(bus.HALTED), 32'd0);
      chk("rst_fault",   32'(bus.FAULT), 32'd0);
      exp_pc = 32'd0; exp_ret = 32'd0; exp_fault = 1'b0; exp_halt = 1'b0;
      bus.EXEC_DONE = 1'b0; bus.INSTR_READY = 1'b0; bus.HALT_REQ = 1'b0;
      bus.JUMP_DEST = 32'd0;
      step();
      rst_n = 1'b1;
      chk("idle_en", 32'(bus.IMEM_EN), 32'd0);
      step();
   endtask

   // One full instruction starting in REQ; ends in REQ or HALT.
   task automatic do_instr(input logic [31:0] jd, input bit hreq,
                           input int unsigned rdy_wait, input int unsigned done_wait,
                           input bit done_in_issue);
      logic [31:0] word;
      word = mem[exp_pc[AW-1:0]];
      chk("req_en",    32'(bus.IMEM_EN), 32'd1);
      chk("req_addr",  32'(bus.IMEM_ADDR), exp_pc & 32'h3FF);
      chk("req_pc",    bus.PC, exp_pc);
      chk("req_valid", 32'(bus.INSTR_VALID), 32'd0);
      bus.EXEC_DONE   = done_in_issue;
      bus.JUMP_DEST   = $urandom;
      bus.HALT_REQ    = 1'($urandom);
      bus.INSTR_READY = 1'b0;
      step();
      chk("wait_en",    32'(bus.IMEM_EN), 32'd0);
      chk("wait_valid", 32'(bus.INSTR_VALID), 32'd0);
      step();
      for (int unsigned k = 0; k <= rdy_wait; k++) begin
         chk("issue_valid", 32'(bus.INSTR_VALID), 32'd1);
         chk("issue_instr", bus.INSTR, word);
         chk("issue_pc",    bus.PC, exp_pc);
         chk("issue_ret",   bus.RETIRED, exp_ret);
         chk("issue_en",    32'(bus.IMEM_EN), 32'd0);
         bus.JUMP_DEST = $urandom;
         if (k == rdy_wait) bus.INSTR_READY = 1'b1;
         step();
      end
      bus.INSTR_READY = 1'b0;
      bus.EXEC_DONE   = 1'b0;
      for (int unsigned k = 0; k <= done_wait; k++) begin
         chk("exec_valid", 32'(bus.INSTR_VALID), 32'd0);
         chk("exec_en",    32'(bus.IMEM_EN), 32'd0);
         chk("exec_ret",   bus.RETIRED, exp_ret);
         chk("exec_pc",    bus.PC, exp_pc);
         if (k == done_wait) begin
            bus.EXEC_DONE = 1'b1;
            bus.JUMP_DEST = jd;
            bus.HALT_REQ  = hreq;
         end else begin
            bus.JUMP_DEST = $urandom;
            bus.HALT_REQ  = 1'($urandom);
         end
         step();
      end
      bus.EXEC_DONE = 1'b0;
      bus.HALT_REQ  = 1'b0;
      exp_ret = exp_ret + 32'd1;
      if (jd >= 32'(1 << AW)) begin
         exp_fault = 1'b1;
         exp_halt  = 1'b1;
      end else begin
         exp_pc   = jd;
         exp_halt = hreq;
      end
      chk("post_ret",    bus.RETIRED, exp_ret);
      chk("post_pc",     bus.PC, exp_pc);
      chk("post_halted", 32'(bus.HALTED), 32'(exp_halt));
      chk("post_fault",  32'(bus.FAULT), 32'(exp_fault));
      chk("post_en",     32'(bus.IMEM_EN), 32'(!exp_halt));
   endtask

   task automatic hold_halt(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         bus.EXEC_DONE   = 1'b1;
         bus.INSTR_READY = 1'b1;
         bus.HALT_REQ    = 1'($urandom);
         bus.JUMP_DEST   = $urandom_range(0, 1023);
         step();
         chk("halt_en",     32'(bus.IMEM_EN), 32'd0);
         chk("halt_valid",  32'(bus.INSTR_VALID), 32'd0);
         chk("halt_halted", 32'(bus.HALTED), 32'd1);
         chk("halt_pc",     bus.PC, exp_pc);
         chk("halt_ret",    bus.RETIRED, exp_ret);
         chk("halt_fault",  32'(bus.FAULT), 32'(exp_fault));
      end
      bus.EXEC_DONE = 1'b0; bus.INSTR_READY = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h00500093;
      rst_n = 1'b0;
      bus.EXEC_DONE = 1'b0; bus.INSTR_READY = 1'b0; bus.HALT_REQ = 1'b0;
      bus.JUMP_DEST = 32'd0;

      // Reset release, then straight-line code 0,1,2 -> 3.
      do_reset();
      for (int i = 0; i < 3; i++) do_instr(exp_pc + 32'd1, 1'b0, 0, 0, 1'b0);
      chk("straight_ret3", bus.RETIRED, 32'd3);

      // Backpressure: five not-ready cycles then one ready cycle.
      do_instr(exp_pc + 32'd1, 1'b0, 5, 0, 1'b0);

      // Branch to 7, then self-loop on 7; EXEC_DONE held high during ISSUE.
      do_instr(32'd7, 1'b0, 0, 2, 1'b1);
      do_instr(32'd7, 1'b0, 1, 0, 1'b1);
      chk("selfloop_pc", bus.PC, 32'd7);

      // Randomized legal traffic including the top legal address.
      for (int i = 0; i < 6; i++)
         do_instr($urandom_range(0, 1023), 1'b0, $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom));
      do_instr(32'd1023, 1'b0, 0, 1, 1'b0);

      // Reset asserted mid-WAIT.
      step();
      chk("midwait_en", 32'(bus.IMEM_EN), 32'd0);
      do_reset();

      // Requested halt: PC takes the jump target, no fault.
      do_instr(32'd1, 1'b0, 0, 0, 1'b0);
      do_instr(32'd5, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
      hold_halt(4);
      chk("hreq_pc", bus.PC, 32'd5);

      // Out-of-range target: sticky fault, PC unchanged, retire still counts.
      do_reset();
      do_instr(32'd3, 1'b0, 0, 0, 1'b0);
      do_instr(32'h0000_0400, 1'b0, 0, 1, 1'b0);
      hold_halt(4);
      chk("fault_pc", bus.PC, 32'd3);

      // Second fault scenario with a large random target.
      do_reset();
      do_instr({1'b1, 31'($urandom)}, 1'b1, 0, 0, 1'b0);
      hold_halt(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net against any unexpected stall of the stimulus sequence.
   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/fetcher.md
# fetcher

Instruction-fetch sequencer that sits directly upstream of the execute stage in the multicycle RISC-V core. It holds the word-indexed program counter and reads the instruction memory, which has synchronous read with 1-cycle latency. It presents the fetched instruction to decode/execute with a valid/ready handshake, then waits for execute to finish. The next PC is taken from the execute stage's `JUMP_DEST`, which is already word-indexed: `pc + 1` for fall-through, or `pc + (imm >>> 2)` for a taken branch or jump.

## Interface
- `RESET_PC`, default 0: word address fetched first after reset.
- `IMEM_ADDR_WIDTH`, default 10: instruction memory word-address width; valid PCs are 0 .. 2^IMEM_ADDR_WIDTH-1.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RSTN` input 1: asynchronous, active-low reset.
- `JUMP_DEST` input 32: next word-indexed PC from execute; sampled only when `EXEC_DONE` is accepted.
- `EXEC_DONE` input 1: execute has finished the current instruction.
- `HALT_REQ` input 1: stop after the current instruction retires.
- `INSTR_READY` input 1: decode accepts `INSTR`.
- `IMEM_DATA` input 32: instruction memory read data, valid one cycle after `IMEM_EN`.
- `IMEM_EN` output 1: instruction memory read enable.
- `IMEM_ADDR` output IMEM_ADDR_WIDTH: equals `PC[IMEM_ADDR_WIDTH-1:0]`.
- `PC` output 32: PC of the instruction being fetched or in flight.
- `INSTR` output 32: latched instruction word.
- `INSTR_VALID` output 1: `INSTR` and `PC` are valid for decode.
- `RETIRED` output 32: count of completed instructions.
- `HALTED` output 1: block is in the HALT state.
- `FAULT` output 1: sticky flag; an out-of-range `JUMP_DEST` was received.

## Operation
- States: IDLE, REQ, WAIT, ISSUE, EXEC, HALT.
- IDLE: entered on reset. Unconditionally goes to REQ on the next edge.
- REQ: `IMEM_EN`=1, `IMEM_ADDR`=`PC`. Goes to WAIT.
- WAIT: `IMEM_EN`=0. At the edge leaving WAIT, `INSTR` <= `IMEM_DATA`. Goes to ISSUE.
- ISSUE: `INSTR_VALID`=1; `INSTR` and `PC` are held stable. If `INSTR_READY`=1, go to EXEC; otherwise stay in ISSUE.
- EXEC: `INSTR_VALID`=0. Waits for `EXEC_DONE`. When `EXEC_DONE`=1:
  - `RETIRED` <= `RETIRED` + 1, wrapping modulo 2^32.
  - If `JUMP_DEST` >= 2^IMEM_ADDR_WIDTH (unsigned compare on all 32 bits): `FAULT` <= 1, `PC` is unchanged, go to HALT.
  - Else if `HALT_REQ`=1: `PC` <= `JUMP_DEST`, go to HALT.
  - Else: `PC` <= `JUMP_DEST`, go to REQ.
- HALT: terminal. All enables are 0, `HALTED`=1. Only reset leaves HALT.
- `EXEC_DONE` outside EXEC is ignored. `INSTR_READY` outside ISSUE is ignored. `HALT_REQ` is sampled only on the EXEC-exit edge.
- `JUMP_DEST` == `PC` (self-loop) is legal and re-fetches the same word.
- `PC` uses 32-bit unsigned arithmetic; this block performs no sign handling.

## Timing
- Reset values (asynchronous, while `RSTN`=0):
  - State=IDLE, `PC`=`RESET_PC`, `INSTR`=0.
  - `INSTR_VALID`=0, `IMEM_EN`=0, `RETIRED`=0, `HALTED`=0, `FAULT`=0.
- Asserting `RSTN` low mid-operation (any state) clears everything immediately, without waiting for a clock edge. No partial retire occurs.
- After `RSTN` rises: edge 1 enters REQ, edge 2 enters WAIT, edge 3 latches `INSTR` and enters ISSUE.
- Minimum cost per instruction, with `INSTR_READY` and `EXEC_DONE` tied high: 4 cycles (REQ, WAIT, ISSUE, EXEC).
- `RETIRED` and `PC` update on the same edge that leaves EXEC.
- The next `IMEM_EN` pulse comes one cycle later, using the new `PC`.
- `HALTED` rises on the edge that enters HALT. `FAULT` rises on that same edge when the cause is out-of-range.
- Outputs `IMEM_EN`, `INSTR_VALID` and `HALTED` are decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- Reset release with `RESET_PC`=0 and `IMEM_DATA` returning 0x00500093 for address 0:
  - `IMEM_EN`=1 with `IMEM_ADDR`=0 in cycle 1.
  - `INSTR_VALID`=1 with `INSTR`=0x00500093 and `PC`=0 from cycle 3.
- Straight-line code, `INSTR_READY`=`EXEC_DONE`=1, `JUMP_DEST`=`PC`+1:
  - `IMEM_EN` pulses every 4 cycles at addresses 0, 1, 2, 3.
  - `RETIRED`=3 after the third EXEC exit.
- Backpressure: hold `INSTR_READY`=0 for 5 cycles in ISSUE, then raise it for 1 cycle.
  - `INSTR` stays stable and `INSTR_VALID`=1 for 6 cycles.
  - Exactly one transition to EXEC; `RETIRED` increments by 1.
- Branch then self-loop: `JUMP_DEST`=7, then `JUMP_DEST`=7.
  - Next fetches are at address 7, then 7 again; `PC`=7 throughout.
- Fault: `JUMP_DEST`=0x00000400 with `IMEM_ADDR_WIDTH`=10.
  - `FAULT`=1, `HALTED`=1, `PC` unchanged, `RETIRED` incremented.
  - No further `IMEM_EN`. `HALT_REQ` with `JUMP_DEST`=5 instead gives `PC`=5, `HALTED`=1, `FAULT`=0.
- Reset pulse mid-WAIT, and `EXEC_DONE`=1 held during ISSUE:
  - Reset: all outputs read their reset values with no clock edge.
  - `EXEC_DONE` in ISSUE: no retire and no `PC` change until EXEC is reached.
